// File: rtl/hex_display_pkg.sv
// Shared types, constants and the round-robin search used by the
// seven-segment display arbiter.
package hex_display_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DATA_W     = 32;
  localparam int MAX_REQ    = 8;

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  // Searches req starting at index ptr and wrapping modulo n.
  // Returns {found, index}; index is meaningless when found is 0.
  // ptr is always below n, so a single conditional subtract wraps.
  function automatic logic [3:0] rr_search(
    input logic [MAX_REQ-1:0] req,
    input logic [2:0]         ptr,
    input int                 n
  );
    logic [3:0] result;
    logic [4:0] pos;
    result = '0;
    pos    = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n && !result[3]) begin
        pos = 5'(ptr) + 5'(k);
        if (pos >= 5'(n)) begin
          pos = pos - 5'(n);
        end
        if (req[pos[2:0]]) begin
          result = {1'b1, pos[2:0]};
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/hex_display_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after the pointer, wrapping. The pointer register lives in the parent.
module rr_arbiter
  import hex_display_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  input  logic         enable,
  output logic [N-1:0] grant,
  output logic [2:0]   grant_idx
);

  logic [MAX_REQ-1:0] req_ext;
  logic [3:0]         pick;

  // Widen the request vector, run the search and decode a one-hot grant.
  always_comb begin
    req_ext          = '0;
    req_ext[N-1:0]   = req;
    pick             = rr_search(req_ext, ptr, N);
    grant_idx        = pick[2:0];
    grant            = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = enable && pick[3] && (pick[2:0] == 3'(i));
    end
  end

endmodule

// File: rtl/hex_display_arbiter.sv
// Shares the 8-digit seven-segment display between N_REQ requesters.
// Ownership rotates round-robin; each grant dwells for HOLD_CYCLES cycles,
// during which only the owner may refresh its value.
module hex_display_arbiter
  import hex_display_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [DATA_W*N_REQ-1:0] req_data,
  input  logic [8*N_REQ-1:0]      req_mask,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    clr,
  output logic [DATA_W-1:0]       hex_data,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic [2:0]              owner,
  output logic                    busy
);

  localparam int            TW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(HOLD_CYCLES - 1);

  state_t                  state;
  logic [TW-1:0]           timer;
  logic [2:0]              ptr;

  logic                    expiry;
  logic                    arb_window;
  logic                    arb_enable;
  logic [N_REQ-1:0]        grant;
  logic [2:0]              grant_idx;
  logic [N_REQ-1:0]        owner_ready;
  logic [N_REQ-1:0]        ready_int;
  logic                    fire;
  logic [2:0]              win_idx;
  logic [2:0]              next_ptr;
  logic [DATA_W-1:0]       win_data;
  logic [NUM_DIGITS-1:0]   win_mask;

  assign expiry     = (state == HOLD) && (timer == TIMER_MAX);
  assign arb_window = (state == IDLE) || expiry;
  assign arb_enable = arb_window && !rst && !clr;

  rr_arbiter #(
    .N(N_REQ)
  ) u_rr (
    .req      (req_valid),
    .ptr      (ptr),
    .enable   (arb_enable),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  // Ready goes to the arbiter winner when ownership is up for grabs,
  // otherwise only the dwelling owner may refresh its value.
  always_comb begin
    owner_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      owner_ready[i] = req_valid[i] && (owner == 3'(i));
    end
    ready_int = '0;
    if (!rst && !clr) begin
      ready_int = arb_window ? grant : owner_ready;
    end
  end

  assign req_ready = ready_int;
  assign fire      = |(req_valid & ready_int);
  assign win_idx   = arb_window ? grant_idx : owner;
  assign next_ptr  = (win_idx == 3'(N_REQ - 1)) ? 3'd0 : win_idx + 3'd1;

  // Select the winning requester's value and digit mask.
  always_comb begin
    win_data = '0;
    win_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == 3'(i)) begin
        win_data = req_data[DATA_W*i +: DATA_W];
        win_mask = req_mask[NUM_DIGITS*i +: NUM_DIGITS];
      end
    end
  end

  // Ownership FSM: grants, dwell timing, refreshes, clear and reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      ptr      <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      hex_data <= '0;
      digit_en <= '0;
    end else if (clr) begin
      state    <= IDLE;
      timer    <= '0;
      busy     <= 1'b0;
      hex_data <= '0;
      digit_en <= '0;
    end else if (arb_window) begin
      if (fire) begin
        state    <= HOLD;
        timer    <= '0;
        ptr      <= next_ptr;
        owner    <= win_idx;
        busy     <= 1'b1;
        hex_data <= win_data;
        digit_en <= win_mask;
      end else begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end else begin
      timer <= timer + 1'b1;
      if (fire) begin
        hex_data <= win_data;
        digit_en <= win_mask;
      end
    end
  end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Scoreboard bench for hex_display_arbiter: directed stimulus pushes
// expected per-cycle outputs, a negedge monitor pops and compares them.
module tb_hex_display_arbiter;

  logic        clk = 1'b0;
  int          cyc = 0;

  logic        rst_a = 1'b1;
  logic        clr_a = 1'b0;
  logic [2:0]  valid_a = '0;
  logic [95:0] data_a = '0;
  logic [23:0] mask_a = '0;
  logic [2:0]  ready_a;
  logic [31:0] hex_a;
  logic [7:0]  en_a;
  logic [2:0]  owner_a;
  logic        busy_a;

  logic        rst_b = 1'b1;
  logic        clr_b = 1'b0;
  logic [2:0]  valid_b = '0;
  logic [95:0] data_b = '0;
  logic [23:0] mask_b = '0;
  logic [2:0]  ready_b;
  logic [31:0] hex_b;
  logic [7:0]  en_b;
  logic [2:0]  owner_b;
  logic        busy_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          at;
    int          dsel;
    bit          full;
    logic [2:0]  ready;
    logic [31:0] hex;
    logic [7:0]  en;
    logic [2:0]  owner;
    logic        busy;
    string       name;
  } exp_t;

  exp_t sb[$];

  hex_display_arbiter #(.N_REQ(3), .HOLD_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst_a), .req_valid(valid_a), .req_data(data_a),
    .req_mask(mask_a), .req_ready(ready_a), .clr(clr_a), .hex_data(hex_a),
    .digit_en(en_a), .owner(owner_a), .busy(busy_a)
  );

  hex_display_arbiter #(.N_REQ(3), .HOLD_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst_b), .req_valid(valid_b), .req_data(data_b),
    .req_mask(mask_b), .req_ready(ready_b), .clr(clr_b), .hex_data(hex_b),
    .digit_en(en_b), .owner(owner_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] valid, input logic clr);
    valid_a = valid;
    clr_a   = clr;
  endtask

  task automatic checkOutput(input string name, input int at, input int dsel,
                             input bit full, input logic [2:0] r,
                             input logic [31:0] h, input logic [7:0] e,
                             input logic [2:0] o, input logic b);
    exp_t x;
    x.at = at; x.dsel = dsel; x.full = full; x.ready = r; x.hex = h;
    x.en = e; x.owner = o; x.busy = b; x.name = name;
    sb.push_back(x);
  endtask

  // Monitor: compares every expectation due in the current cycle.
  always @(negedge clk) begin
    logic [2:0]  ar;
    logic [31:0] ah;
    logic [7:0]  ae;
    logic [2:0]  ao;
    logic        ab;
    logic        bad;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        if (sb[i].dsel == 0) begin
          ar = ready_a; ah = hex_a; ae = en_a; ao = owner_a; ab = busy_a;
        end else begin
          ar = ready_b; ah = hex_b; ae = en_b; ao = owner_b; ab = busy_b;
        end
        bad = (ar !== sb[i].ready);
        if (sb[i].full) begin
          bad = bad || (ah !== sb[i].hex) || (ae !== sb[i].en) ||
                (ao !== sb[i].owner) || (ab !== sb[i].busy);
        end
        checks++;
        if (bad) begin
          errors++;
          $display("[TB] FAIL %s cyc=%0d ready got %b want %b hex got %h want %h en got %h want %h owner got %0d want %0d busy got %b want %b",
                   sb[i].name, cyc, ar, sb[i].ready, ah, sb[i].hex, ae, sb[i].en,
                   ao, sb[i].owner, ab, sb[i].busy);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    int t;

    // Reset state
    tick(2);

    // Direct checks while both instances are held in reset
    checks++;
    if (hex_a !== 32'h0) begin
      errors++;
      $display("[TB] FAIL rst_a hex_data got %h want 0", hex_a);
    end
    checks++;
    if (en_a !== 8'h00) begin
      errors++;
      $display("[TB] FAIL rst_a digit_en got %h want 00", en_a);
    end
    checks++;
    if (owner_a !== 3'd0) begin
      errors++;
      $display("[TB] FAIL rst_a owner got %0d want 0", owner_a);
    end
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_a busy got %b want 0", busy_a);
    end
    checks++;
    if (ready_a !== 3'b000) begin
      errors++;
      $display("[TB] FAIL rst_a req_ready got %b want 000", ready_a);
    end
    checks++;
    if (hex_b !== 32'h0) begin
      errors++;
      $display("[TB] FAIL rst_b hex_data got %h want 0", hex_b);
    end
    checks++;
    if (en_b !== 8'h00) begin
      errors++;
      $display("[TB] FAIL rst_b digit_en got %h want 00", en_b);
    end
    checks++;
    if (owner_b !== 3'd0) begin
      errors++;
      $display("[TB] FAIL rst_b owner got %0d want 0", owner_b);
    end
    checks++;
    if (busy_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_b busy got %b want 0", busy_b);
    end
    checks++;
    if (ready_b !== 3'b000) begin
      errors++;
      $display("[TB] FAIL rst_b req_ready got %b want 000", ready_b);
    end

    rst_a = 1'b0;
    t = cyc;
    checkOutput("reset_state", t, 0, 1, 3'b000, 32'h0, 8'h00, 3'd0, 1'b0);
    tick(1);

    // Basic grant of 0 then expiry hand-over to 2, then idle with display kept
    t = cyc;
    data_a[31:0]  = 32'h0000_1234; mask_a[7:0]   = 8'h0F;
    data_a[95:64] = 32'hDEAD_BEEF; mask_a[23:16] = 8'hFF;
    applyStimulus(3'b101, 1'b0);
    checkOutput("t1_ready0", t, 0, 0, 3'b001, '0, '0, '0, 1'b0);
    checkOutput("t1_disp0", t + 1, 0, 1, 3'b000, 32'h0000_1234, 8'h0F, 3'd0, 1'b1);
    checkOutput("t1_expiry_ready2", t + 4, 0, 0, 3'b100, '0, '0, '0, 1'b0);
    checkOutput("t1_disp2", t + 5, 0, 1, 3'b000, 32'hDEAD_BEEF, 8'hFF, 3'd2, 1'b1);
    checkOutput("t1_idle_retained", t + 9, 0, 1, 3'b000, 32'hDEAD_BEEF, 8'hFF, 3'd2, 1'b0);
    tick(1);
    applyStimulus(3'b100, 1'b0);
    tick(4);
    applyStimulus(3'b000, 1'b0);
    tick(5);

    // Owner refresh does not extend dwell; then req 1 alone re-granted
    t = cyc;
    data_a[31:0]  = 32'h0000_1234; mask_a[7:0]  = 8'h0F;
    data_a[63:32] = 32'hCAFE_0001; mask_a[15:8] = 8'hF0;
    applyStimulus(3'b001, 1'b0);
    checkOutput("t2_ready0", t, 0, 0, 3'b001, '0, '0, '0, 1'b0);
    checkOutput("t2_disp0", t + 1, 0, 1, 3'b000, 32'h0000_1234, 8'h0F, 3'd0, 1'b1);
    checkOutput("t2_refresh_ready", t + 2, 0, 0, 3'b001, '0, '0, '0, 1'b0);
    checkOutput("t2_refresh_disp", t + 3, 0, 1, 3'b000, 32'h0000_0001, 8'h0F, 3'd0, 1'b1);
    checkOutput("t2_orig_expiry", t + 4, 0, 0, 3'b010, '0, '0, '0, 1'b0);
    checkOutput("t2_disp1", t + 5, 0, 1, 3'b010, 32'hCAFE_0001, 8'hF0, 3'd1, 1'b1);
    checkOutput("t3_regrant_ready", t + 8, 0, 0, 3'b010, '0, '0, '0, 1'b0);
    checkOutput("t3_regrant_busy", t + 9, 0, 1, 3'b010, 32'hCAFE_0001, 8'hF0, 3'd1, 1'b1);
    checkOutput("t3_regrant2_ready", t + 12, 0, 0, 3'b010, '0, '0, '0, 1'b0);
    checkOutput("t3_last_hold", t + 13, 0, 1, 3'b000, 32'hCAFE_0001, 8'hF0, 3'd1, 1'b1);
    checkOutput("t3_expiry_still_busy", t + 16, 0, 1, 3'b000, 32'hCAFE_0001, 8'hF0, 3'd1, 1'b1);
    checkOutput("t3_idle_retained", t + 17, 0, 1, 3'b000, 32'hCAFE_0001, 8'hF0, 3'd1, 1'b0);
    tick(1);
    applyStimulus(3'b010, 1'b0);
    tick(1);
    data_a[31:0] = 32'h0000_0001;
    applyStimulus(3'b011, 1'b0);
    tick(1);
    applyStimulus(3'b010, 1'b0);
    tick(10);
    applyStimulus(3'b000, 1'b0);
    tick(5);

    // clr mid-HOLD with req 2 waiting, then reset mid-HOLD with all valid
    t = cyc;
    data_a[31:0]  = 32'h0000_0055; mask_a[7:0]   = 8'h03;
    data_a[95:64] = 32'h1357_9BDF; mask_a[23:16] = 8'hFF;
    applyStimulus(3'b001, 1'b0);
    checkOutput("t4_ready0_from_ptr2", t, 0, 0, 3'b001, '0, '0, '0, 1'b0);
    checkOutput("t4_disp0", t + 1, 0, 1, 3'b000, 32'h0000_0055, 8'h03, 3'd0, 1'b1);
    checkOutput("t4_clr_ready", t + 2, 0, 0, 3'b000, '0, '0, '0, 1'b0);
    checkOutput("t4_cleared", t + 3, 0, 1, 3'b100, 32'h0, 8'h00, 3'd0, 1'b0);
    checkOutput("t4_disp2_after_clr", t + 4, 0, 1, 3'b100, 32'h1357_9BDF, 8'hFF, 3'd2, 1'b1);
    checkOutput("t5_rst_ready", t + 6, 0, 0, 3'b000, '0, '0, '0, 1'b0);
    checkOutput("t5_rst_state", t + 7, 0, 1, 3'b000, 32'h0, 8'h00, 3'd0, 1'b0);
    checkOutput("t5_ptr_reset_ready", t + 8, 0, 0, 3'b001, '0, '0, '0, 1'b0);
    checkOutput("t5_disp0", t + 9, 0, 1, 3'b000, 32'h0000_0055, 8'h03, 3'd0, 1'b1);
    tick(1);
    applyStimulus(3'b100, 1'b0);
    tick(1);
    applyStimulus(3'b100, 1'b1);
    tick(1);
    applyStimulus(3'b100, 1'b0);
    tick(1);
    applyStimulus(3'b111, 1'b0);
    tick(2);
    rst_a = 1'b1;
    tick(2);
    rst_a = 1'b0;
    tick(1);
    applyStimulus(3'b000, 1'b0);
    tick(2);

    // HOLD_CYCLES=1: grants rotate every cycle
    t = cyc;
    rst_b   = 1'b0;
    data_b  = {32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0};
    mask_b  = {8'h04, 8'h02, 8'h01};
    valid_b = 3'b111;
    checkOutput("t6_c0", t, 1, 1, 3'b001, 32'h0, 8'h00, 3'd0, 1'b0);
    checkOutput("t6_c1", t + 1, 1, 1, 3'b010, 32'hA0A0_A0A0, 8'h01, 3'd0, 1'b1);
    checkOutput("t6_c2", t + 2, 1, 1, 3'b100, 32'hB1B1_B1B1, 8'h02, 3'd1, 1'b1);
    checkOutput("t6_c3", t + 3, 1, 1, 3'b001, 32'hC2C2_C2C2, 8'h04, 3'd2, 1'b1);
    checkOutput("t6_c4", t + 4, 1, 1, 3'b010, 32'hA0A0_A0A0, 8'h01, 3'd0, 1'b1);
    tick(6);

    // Any expectation never reached counts as a failure
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s not reached: due cyc %0d, now %0d", sb[0].name, sb[0].at, cyc);
      void'(sb.pop_front());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_display_arbiter.md
Name: hex_display_arbiter

Overview:
- Shares the 8-digit seven-segment display between N_REQ requesters, e.g. a debug counter, a status word and a user-entry register.
- Each requester offers a 32-bit value and an 8-bit digit-enable mask over a valid/ready handshake.
- The block grants the display round-robin and holds each owner for a minimum dwell time.
- It drives the registered hex_data/digit_en pair into the seven-segment decoder stage.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- HOLD_CYCLES, 50000000, minimum display cycles per grant (>=1; 1 s at 50 MHz).
- TW, $clog2(HOLD_CYCLES+1), hold-timer width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  requester i offers a value; held with its data until accepted.
- req_data  in  32*N_REQ  packed values; slice i = [32*i+31:32*i]; nibble k goes to digit k.
- req_mask  in  8*N_REQ  packed digit enables; slice i = [8*i+7:8*i]; bit k=1 lights digit k.
- req_ready  out  N_REQ  one-hot or zero; transfer when req_valid[i] & req_ready[i].
- clr  in  1  blank the display and release ownership.
- hex_data  out  32  displayed value (registered).
- digit_en  out  8  per-digit enable (registered); 0 = blanked digit.
- owner  out  3  index of current/last owner.
- busy  out  1  1 while in HOLD.

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high (clk, rst).
  - On rst: hex_data=0, digit_en=0 (all blank), owner=0, busy=0, req_ready=0, state=IDLE, timer=0.
  - Round-robin pointer=0, so requester 0 has first priority.
  - Reset mid-HOLD aborts immediately; no handshake completes in the rst cycle.
- States: IDLE (no holder, display keeps last value) and HOLD (owner dwelling).
- req_ready (combinational from state, timer, pointer and req_valid; never asserted while rst or clr=1):
  - IDLE: ready goes to the round-robin winner among valid requesters.
  - HOLD, timer < HOLD_CYCLES-1: ready[owner]=req_valid[owner]. The owner may refresh its value; a refresh does NOT restart the timer.
  - HOLD, timer == HOLD_CYCLES-1 (expiry): ready goes to the round-robin winner, searching from owner+1 and wrapping. The owner is considered last, so any other valid requester wins.
- Transfer at cycle t (handshake with winner w):
  - At t+1: hex_data=req_data[w], digit_en=req_mask[w], owner=w, busy=1, state=HOLD.
  - The timer resets to 0 at t+1 only for a new grant (an expiry or IDLE handshake), not for an owner refresh.
  - The pointer becomes w+1 mod N_REQ.
  - Latency: 1 cycle.
- Expiry outcomes:
  - No valid requester: go to IDLE at the next cycle, busy=0, display unchanged.
  - Only the owner valid: the owner is re-granted and the timer restarts.
- Dwell: each grant shows for exactly HOLD_CYCLES cycles before another requester can take over, provided someone else is waiting.
- clr:
  - Highest priority below rst.
  - Next cycle: digit_en=0, hex_data=0, state=IDLE, busy=0; pointer and owner unchanged.
  - Any valid held during clr is served after clr deasserts.
- Requester protocol: data and mask are sampled only on the handshake cycle. Deasserting valid before ready is a protocol violation; behaviour on the display is then undefined, but the FSM stays legal.
- Timer:
  - Saturates at HOLD_CYCLES-1 and never wraps.
  - With HOLD_CYCLES=1, every HOLD cycle is an expiry cycle.

Decomposition:
- Package hex_display_pkg holds:
  - NUM_DIGITS=8 and DATA_W=32.
  - The state enum {IDLE, HOLD}.
  - A function for the round-robin search.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant and its index.
  - Purely combinational; the pointer register lives in the parent.

Test Plan (N_REQ=3, HOLD_CYCLES=4 unless noted):
- Reset, then req_valid=3'b101 at cycle 0 (data0=32'h0000_1234, mask0=8'h0F; data2=32'hDEAD_BEEF, mask2=8'hFF):
  - ready=3'b001 at cycle 0; hex_data=32'h0000_1234 and digit_en=8'h0F at cycle 1.
  - ready=3'b100 at cycle 4; hex_data=32'hDEAD_BEEF and owner=2 at cycle 5.
- Owner 0 in HOLD refreshes with 32'h0000_0001 at timer=1 while req 1 waits:
  - Display updates the next cycle.
  - Req 1 is still granted at original expiry, at cycle 4 after the initial grant.
- Single requester 1 valid continuously:
  - Re-granted every 4 cycles; busy stays 1.
  - Drop valid, and at the next expiry busy=0 with the display retained.
- clr pulse mid-HOLD with req 2 valid:
  - Next cycle digit_en=8'h00 and hex_data=0.
  - After clr deasserts, req 2 is granted in IDLE the following cycle.
- rst asserted at timer=2 with all valid:
  - Next cycle all outputs are zero and req_ready=0.
  - After release, req 0 wins first (pointer reset).
- HOLD_CYCLES=1, all three continuously valid: grants rotate 0,1,2,0 on consecutive cycles and owner follows one cycle later.
